// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the 16-entry synchronous FIFO built around
// the synchronous dual-port RAM.
//   RAM_DEPTH / ADD_SIZE : RAM geometry (RAM_DEPTH == 2**ADD_SIZE)
//   RAM_WIDTH            : RAM data width, shared with the RAM itself
//   ptr_t                : read/write pointer, one extra wrap bit above the address
//   cnt_t                : occupancy, 0..RAM_DEPTH inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int ADD_SIZE  = 4;
    localparam int RAM_DEPTH = 16;
    localparam int RAM_WIDTH = 8;

    typedef logic [ADD_SIZE:0] ptr_t;
    typedef logic [ADD_SIZE:0] cnt_t;

    localparam ptr_t PTR_ZERO = {(ADD_SIZE + 1){1'b0}};
    localparam ptr_t PTR_ONE  = {{ADD_SIZE{1'b0}}, 1'b1};
    localparam cnt_t CNT_ZERO = {(ADD_SIZE + 1){1'b0}};
    localparam cnt_t CNT_ONE  = {{ADD_SIZE{1'b0}}, 1'b1};

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrapping ADD_SIZE+1-bit pointer. The low ADD_SIZE bits address the RAM and
// the MSB toggles on each pass through the RAM, which lets full and empty be
// told apart when the addresses coincide.
//   clk : clock, rising edge
//   rst : synchronous, active-low reset (pointer -> 0)
//   inc : advance by one this cycle
//   ptr : current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output ptr_t ptr
);

    ptr_t ptr_d;
    ptr_t ptr_q;

    // Next pointer: wraps from all-ones back to zero by natural overflow.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + PTR_ONE;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= PTR_ZERO;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : fifo_ptr

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Pointer and flag controller turning the synchronous dual-port RAM into a
// 16-entry synchronous FIFO. Data never passes through here: producers drive
// the RAM data_in, consumers take the RAM data_out.
//   clk, rst            : clock; synchronous active-low reset
//   wr_req, rd_req      : push / pop requests
//   clr_err             : clears the sticky overflow/underflow flags
//   ram_write, ram_read : combinational RAM strobes (accepted push / pop)
//   ram_write_add,
//   ram_read_add        : combinational RAM addresses (low pointer bits)
//   rd_valid            : RAM data_out holds the word popped last cycle
//   full, empty,
//   almost_full,
//   almost_empty, count : registered occupancy and status
//   overflow, underflow : sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                clr_err,
    output logic                ram_write,
    output logic                ram_read,
    output logic [ADD_SIZE-1:0] ram_write_add,
    output logic [ADD_SIZE-1:0] ram_read_add,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADD_SIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    ptr_t wr_ptr_s;
    ptr_t rd_ptr_s;
    logic push_ok_s;
    logic pop_ok_s;

    cnt_t count_d,        count_q;
    logic full_d,         full_q;
    logic empty_d,        empty_q;
    logic almost_full_d,  almost_full_q;
    logic almost_empty_d, almost_empty_q;
    logic rd_valid_d,     rd_valid_q;
    logic overflow_d,     overflow_q;
    logic underflow_d,    underflow_q;

    // Accept decisions use only this cycle's registered flags: a push at full
    // is refused even when a pop is accepted in the same cycle, and vice versa.
    always_comb begin
        push_ok_s = wr_req & ~full_q;
        pop_ok_s  = rd_req & ~empty_q;
    end

    fifo_ptr u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok_s),
        .ptr (wr_ptr_s)
    );

    fifo_ptr u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok_s),
        .ptr (rd_ptr_s)
    );

    // Occupancy, flags derived from the next count, read-valid and sticky errors.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d         = (count_d == cnt_t'(RAM_DEPTH));
        empty_d        = (count_d == CNT_ZERO);
        almost_full_d  = (count_d >= cnt_t'(AF_THRESH));
        almost_empty_d = (count_d <= cnt_t'(AE_THRESH));

        // The RAM read is registered, so data appears one cycle after the pop.
        rd_valid_d = pop_ok_s;

        // A new error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (wr_req & full_q)  | (overflow_q  & ~clr_err);
        underflow_d = (rd_req & empty_q) | (underflow_q & ~clr_err);
    end

    // Status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q        <= CNT_ZERO;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            rd_valid_q     <= rd_valid_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // RAM strobes and addresses are combinational so the RAM samples them on
    // the same edge that advances the pointers.
    assign ram_write     = push_ok_s;
    assign ram_read      = pop_ok_s;
    assign ram_write_add = wr_ptr_s[ADD_SIZE-1:0];
    assign ram_read_add  = rd_ptr_s[ADD_SIZE-1:0];

    assign rd_valid      = rd_valid_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign almost_full   = almost_full_q;
    assign almost_empty  = almost_empty_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule : sync_fifo_ctrl
